id_ex_pipe_reg: RTL and testbench

- ID/EX pipeline register sitting directly downstream of the ID-stage control mux (the stall-zeroing mux between Control/Hazard_Detection_Unit and EX).
- Captures the muxed control bundle plus ID-stage operands each cycle and presents them to the EX stage.
- Supports a whole-pipe freeze (hold), a branch flush that inserts a bubble, and a saturating bubble counter for debug/performance.

---
 rtl/id_ex_pipe_reg.sv | 136 +++++++++++++
 tb/tb_id_ex_pipe_reg.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register: captures the muxed control bundle and ID operands for EX,
// with freeze, branch-flush bubble insertion and a saturating bubble counter.
module id_ex_pipe_reg #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              hold_i,
    input  logic              flush_i,
    input  logic              valid_i,
    input  logic              ALUSrc_i,
    input  logic              MemToReg_i,
    input  logic              RegWrite_i,
    input  logic              MemWrite_i,
    input  logic              MemRead_i,
    input  logic              Branch_i,
    input  logic [1:0]        ALUOp_i,
    input  logic [DATA_W-1:0] RS1data_i,
    input  logic [DATA_W-1:0] RS2data_i,
    input  logic [DATA_W-1:0] imm_i,
    input  logic [DATA_W-1:0] pc_i,
    input  logic [9:0]        funct_i,
    input  logic [REG_AW-1:0] RS1addr_i,
    input  logic [REG_AW-1:0] RS2addr_i,
    input  logic [REG_AW-1:0] RDaddr_i,
    output logic              ALUSrc_o,
    output logic              MemToReg_o,
    output logic              RegWrite_o,
    output logic              MemWrite_o,
    output logic              MemRead_o,
    output logic              Branch_o,
    output logic [1:0]        ALUOp_o,
    output logic [DATA_W-1:0] RS1data_o,
    output logic [DATA_W-1:0] RS2data_o,
    output logic [DATA_W-1:0] imm_o,
    output logic [DATA_W-1:0] pc_o,
    output logic [9:0]        funct_o,
    output logic [REG_AW-1:0] RS1addr_o,
    output logic [REG_AW-1:0] RS2addr_o,
    output logic [REG_AW-1:0] RDaddr_o,
    output logic              valid_o,
    output logic [CNT_W-1:0]  bubble_cnt_o
);

    // Control bundle packed as {ALUSrc, MemToReg, RegWrite, MemWrite, MemRead, Branch, ALUOp}
    logic [7:0] ctrlIn;
    logic [7:0] ctrlNext;
    logic [7:0] ctrlReg;
    logic       validNext;
    logic       loadEn;
    logic       bubbleEdge;

    assign ctrlIn = {ALUSrc_i, MemToReg_i, RegWrite_i, MemWrite_i,
                     MemRead_i, Branch_i, ALUOp_i};

    assign loadEn = ~hold_i;

    always_comb begin
        validNext = 1'b0;
        ctrlNext  = '0;
        if (!flush_i) begin
            validNext = valid_i;
            // An invalid slot must never carry side-effecting controls into EX
            ctrlNext  = valid_i ? ctrlIn : 8'h00;
        end
    end

    assign bubbleEdge = loadEn & ~validNext;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ctrlReg <= '0;
            valid_o <= 1'b0;
        end else if (loadEn) begin
            ctrlReg <= ctrlNext;
            valid_o <= validNext;
        end
    end

    // Data and addresses are cleared on flush so a bubble's RDaddr is x0
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            RS1data_o <= '0;
            RS2data_o <= '0;
            imm_o     <= '0;
            pc_o      <= '0;
            funct_o   <= '0;
        end else if (loadEn) begin
            if (flush_i) begin
                RS1data_o <= '0;
                RS2data_o <= '0;
                imm_o     <= '0;
                pc_o      <= '0;
                funct_o   <= '0;
            end else begin
                RS1data_o <= RS1data_i;
                RS2data_o <= RS2data_i;
                imm_o     <= imm_i;
                pc_o      <= pc_i;
                funct_o   <= funct_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            RS1addr_o <= '0;
            RS2addr_o <= '0;
            RDaddr_o  <= '0;
        end else if (loadEn) begin
            if (flush_i) begin
                RS1addr_o <= '0;
                RS2addr_o <= '0;
                RDaddr_o  <= '0;
            end else begin
                RS1addr_o <= RS1addr_i;
                RS2addr_o <= RS2addr_i;
                RDaddr_o  <= RDaddr_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            bubble_cnt_o <= '0;
        end else if (bubbleEdge && (bubble_cnt_o != {CNT_W{1'b1}})) begin
            bubble_cnt_o <= bubble_cnt_o + 1'b1;
        end
    end

    assign {ALUSrc_o, MemToReg_o, RegWrite_o, MemWrite_o,
            MemRead_o, Branch_o, ALUOp_o} = ctrlReg;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed + randomized bench for id_ex_pipe_reg against a behavioural model of the
// hold/flush/load rules; a second instance with a 4-bit counter covers saturation.
module tb_id_ex_pipe_reg;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        hold = 1'b0, flush = 1'b0, valid = 1'b0;
    logic        aluSrc = 0, memToReg = 0, regWrite = 0, memWrite = 0, memRead = 0, branch = 0;
    logic [1:0]  aluOp = 0;
    logic [31:0] rs1d = 0, rs2d = 0, imm = 0, pc = 0;
    logic [9:0]  funct = 0;
    logic [4:0]  rs1a = 0, rs2a = 0, rda = 0;

    logic        oAluSrc, oMemToReg, oRegWrite, oMemWrite, oMemRead, oBranch, oValid;
    logic [1:0]  oAluOp;
    logic [31:0] oRs1d, oRs2d, oImm, oPc;
    logic [9:0]  oFunct;
    logic [4:0]  oRs1a, oRs2a, oRda;
    logic [15:0] oCnt;

    logic        sAluSrc, sMemToReg, sRegWrite, sMemWrite, sMemRead, sBranch, sValid;
    logic [1:0]  sAluOp;
    logic [31:0] sRs1d, sRs2d, sImm, sPc;
    logic [9:0]  sFunct;
    logic [4:0]  sRs1a, sRs2a, sRda;
    logic [3:0]  sCnt;

    int checks = 0;
    int errors = 0;

    // Expected state
    logic [7:0]  eCtrl;
    logic [31:0] eRs1d, eRs2d, eImm, ePc;
    logic [9:0]  eFunct;
    logic [4:0]  eRs1a, eRs2a, eRda;
    logic        eValid;
    int          eCnt, eCntSat;

    always #5 clk = ~clk;

    id_ex_pipe_reg dut (
        .clk_i(clk), .rst_i(rst), .hold_i(hold), .flush_i(flush), .valid_i(valid),
        .ALUSrc_i(aluSrc), .MemToReg_i(memToReg), .RegWrite_i(regWrite),
        .MemWrite_i(memWrite), .MemRead_i(memRead), .Branch_i(branch), .ALUOp_i(aluOp),
        .RS1data_i(rs1d), .RS2data_i(rs2d), .imm_i(imm), .pc_i(pc), .funct_i(funct),
        .RS1addr_i(rs1a), .RS2addr_i(rs2a), .RDaddr_i(rda),
        .ALUSrc_o(oAluSrc), .MemToReg_o(oMemToReg), .RegWrite_o(oRegWrite),
        .MemWrite_o(oMemWrite), .MemRead_o(oMemRead), .Branch_o(oBranch), .ALUOp_o(oAluOp),
        .RS1data_o(oRs1d), .RS2data_o(oRs2d), .imm_o(oImm), .pc_o(oPc), .funct_o(oFunct),
        .RS1addr_o(oRs1a), .RS2addr_o(oRs2a), .RDaddr_o(oRda),
        .valid_o(oValid), .bubble_cnt_o(oCnt)
    );

    id_ex_pipe_reg #(.CNT_W(4)) dutSat (
        .clk_i(clk), .rst_i(rst), .hold_i(hold), .flush_i(flush), .valid_i(valid),
        .ALUSrc_i(aluSrc), .MemToReg_i(memToReg), .RegWrite_i(regWrite),
        .MemWrite_i(memWrite), .MemRead_i(memRead), .Branch_i(branch), .ALUOp_i(aluOp),
        .RS1data_i(rs1d), .RS2data_i(rs2d), .imm_i(imm), .pc_i(pc), .funct_i(funct),
        .RS1addr_i(rs1a), .RS2addr_i(rs2a), .RDaddr_i(rda),
        .ALUSrc_o(sAluSrc), .MemToReg_o(sMemToReg), .RegWrite_o(sRegWrite),
        .MemWrite_o(sMemWrite), .MemRead_o(sMemRead), .Branch_o(sBranch), .ALUOp_o(sAluOp),
        .RS1data_o(sRs1d), .RS2data_o(sRs2d), .imm_o(sImm), .pc_o(sPc), .funct_o(sFunct),
        .RS1addr_o(sRs1a), .RS2addr_o(sRs2a), .RDaddr_o(sRda),
        .valid_o(sValid), .bubble_cnt_o(sCnt)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        eCtrl = 0; eRs1d = 0; eRs2d = 0; eImm = 0; ePc = 0; eFunct = 0;
        eRs1a = 0; eRs2a = 0; eRda = 0; eValid = 0; eCnt = 0; eCntSat = 0;
    endtask

    // Reference: held edges change nothing; otherwise a flush or invalid slot is a bubble
    task automatic modelEdge();
        if (!rst || hold) return;
        if (flush) begin
            eCtrl = 0; eRs1d = 0; eRs2d = 0; eImm = 0; ePc = 0; eFunct = 0;
            eRs1a = 0; eRs2a = 0; eRda = 0; eValid = 0;
        end else begin
            eCtrl  = valid ? {aluSrc, memToReg, regWrite, memWrite, memRead, branch, aluOp} : 8'h00;
            eRs1d  = rs1d; eRs2d = rs2d; eImm = imm; ePc = pc; eFunct = funct;
            eRs1a  = rs1a; eRs2a = rs2a; eRda = rda; eValid = valid;
        end
        if (!eValid) begin
            if (eCnt < 65535) eCnt++;
            if (eCntSat < 15) eCntSat++;
        end
    endtask

    task automatic checkAll(input string step);
        logic [7:0] ctrl;
        logic [7:0] ctrlSat;
        ctrl    = {oAluSrc, oMemToReg, oRegWrite, oMemWrite, oMemRead, oBranch, oAluOp};
        ctrlSat = {sAluSrc, sMemToReg, sRegWrite, sMemWrite, sMemRead, sBranch, sAluOp};
        check({step, ":ctrl"},  64'(ctrl), 64'(eCtrl));
        check({step, ":data"},  {oRs1d, oRs2d}, {eRs1d, eRs2d});
        check({step, ":immpc"}, {oImm, oPc}, {eImm, ePc});
        check({step, ":addr"},  64'({oFunct, oRs1a, oRs2a, oRda}), 64'({eFunct, eRs1a, eRs2a, eRda}));
        check({step, ":valid"}, 64'(oValid), 64'(eValid));
        check({step, ":cnt"},   64'(oCnt), 64'(eCnt));
        check({step, ":cntSat"}, 64'(sCnt), 64'(eCntSat));
        check({step, ":satCopy"}, 64'({ctrlSat, sValid, sRda}), 64'({eCtrl, eValid, eRda}));
        if (!oValid)
            check({step, ":invariant"}, 64'({oRegWrite, oMemWrite, oMemRead, oBranch}), 64'(0));
        $display("step %-10s hold=%0b flush=%0b valid_i=%0b -> valid_o=%0b rd=%0d cnt=%0d cntSat=%0d",
                 step, hold, flush, valid, oValid, oRda, oCnt, sCnt);
    endtask

    task automatic randInputs();
        {aluSrc, memToReg, regWrite, memWrite, memRead, branch} = 6'($urandom);
        aluOp = 2'($urandom);
        rs1d = $urandom; rs2d = $urandom; imm = $urandom; pc = $urandom;
        funct = 10'($urandom);
        rs1a = 5'($urandom); rs2a = 5'($urandom); rda = 5'($urandom);
    endtask

    task automatic clearInputs();
        {aluSrc, memToReg, regWrite, memWrite, memRead, branch} = 6'b0;
        aluOp = 0; rs1d = 0; rs2d = 0; imm = 0; pc = 0; funct = 0;
        rs1a = 0; rs2a = 0; rda = 0;
    endtask

    // Inputs are set before calling; apply one edge, advance the model, check
    task automatic edgeStep(input string step);
        @(posedge clk);
        modelEdge();
        #1;
        checkAll(step);
        @(negedge clk);
    endtask

    initial begin
        modelReset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 checkAll("reset");
        @(negedge clk);
        rst = 1'b1;

        // First capture after reset
        clearInputs();
        regWrite = 1; aluOp = 2'b10; rs1d = 32'h5; rda = 5'd3; valid = 1;
        edgeStep("firstLoad");
        check("firstLoad:rs1", 64'(oRs1d), 64'h5);
        check("firstLoad:rd", 64'(oRda), 64'd3);

        // Flush over a valid add with a stray store
        randInputs(); memWrite = 0; valid = 1;
        edgeStep("validAdd");
        randInputs(); memWrite = 1; flush = 1;
        edgeStep("flush");
        check("flush:cnt", 64'(oCnt), 64'd1);
        flush = 0; randInputs();
        edgeStep("afterFlush");

        // Hold dominates flush
        hold = 1; flush = 1;
        for (int i = 0; i < 3; i++) begin
            randInputs(); valid = 1'($urandom);
            edgeStep("holdFlush");
        end
        hold = 0; randInputs();
        edgeStep("flushRel");
        check("flushRel:cnt", 64'(oCnt), 64'd2);
        flush = 0;

        // Load-use bubble with stray MemRead
        randInputs(); memRead = 1; valid = 0;
        edgeStep("loadUse");
        check("loadUse:memRead", 64'(oMemRead), 64'd0);
        valid = 1;
        edgeStep("loadUseRel");
        check("loadUseRel:memRead", 64'(oMemRead), 64'd1);

        // Randomized mix of hold, flush and invalid slots
        for (int i = 0; i < 60; i++) begin
            randInputs();
            hold  = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 3) == 0);
            valid = ($urandom_range(0, 2) != 0);
            edgeStep("random");
        end
        hold = 0; valid = 1;

        // Saturation of the 4-bit counter
        flush = 1;
        for (int i = 0; i < 20; i++) begin
            randInputs();
            edgeStep("satFlush");
        end
        check("sat:cnt4", 64'(sCnt), 64'hF);
        flush = 0;

        // Asynchronous reset with valid_o=1 and counter at 7
        rst = 0; #1 modelReset(); rst = 1;
        @(negedge clk);
        flush = 1;
        for (int i = 0; i < 7; i++) begin
            randInputs();
            edgeStep("preReset");
        end
        flush = 0; valid = 1; randInputs(); regWrite = 1; rda = 5'd9;
        edgeStep("preResetLd");
        check("preReset:cnt7", 64'(oCnt), 64'd7);
        check("preReset:valid", 64'(oValid), 64'd1);
        #2 rst = 0;
        #1;
        modelReset();
        checkAll("asyncReset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
